// File: rtl/dec_byte_serializer.sv
// dec_byte_serializer: tracks issued decrypter cycles, buffers plaintext words and streams them out MSB byte first
module dec_byte_serializer #(
  parameter int N       = 256,
  parameter int LATENCY = 5,
  parameter int DEPTH   = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     issue_valid,
  output logic                     issue_ready,
  input  logic [N-1:0]             dec_data,
  output logic [7:0]               byte_out,
  output logic                     byte_valid,
  input  logic                     byte_ready,
  output logic                     byte_last,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   credits
);
  localparam int NB = N / 8;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [BW-1:0] LAST_BYTE = BW'(NB - 1);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;
  logic [0:0]     state;
  logic [LATENCY:0] vline;
  logic [N-1:0]   mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  count, count_nxt;
  logic [BW-1:0]  bcnt;
  logic [N-1:0]   head, shifted;
  logic           accept, wr_en, fire, pop;
  assign fire        = byte_valid && byte_ready;
  assign pop         = fire && byte_last;
  assign issue_ready = (credits != '0) || pop;
  assign accept      = issue_valid && issue_ready;
  assign wr_en       = vline[LATENCY];
  assign count_nxt   = count + CW'(wr_en) - CW'(pop);
  assign head        = mem[rd_ptr];
  assign shifted     = head << {bcnt, 3'b000};
  assign byte_valid  = (state == SEND);
  assign byte_out    = byte_valid ? shifted[N-1 -: 8] : 8'h00;
  assign byte_last   = byte_valid && (bcnt == LAST_BYTE);
  // Issue tracking: dec_data for an issue sampled at edge k is valid in the cycle after edge k+LATENCY
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) vline <= '0;
    else vline <= {vline[LATENCY-1:0], accept};
  // Word FIFO: a write and a pop in the same cycle are both honoured
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      mem    <= '{default: '0};
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) mem[wr_ptr] <= dec_data;
      wr_ptr <= wr_en ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr <= pop ? rd_ptr + AW'(1) : rd_ptr;
      count  <= count_nxt;
    end
  // Output FSM and byte counter: stays in SEND across words so consecutive words have no bubble
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      bcnt  <= '0;
    end else begin
      state <= (count_nxt != '0) ? SEND : IDLE;
      bcnt  <= fire ? (byte_last ? '0 : bcnt + BW'(1)) : bcnt;
    end
  // Credit accounting: a slot is reserved at issue and released on the last-byte handshake
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      credits  <= CW'(DEPTH);
      overflow <= 1'b0;
    end else begin
      credits  <= credits - CW'(accept) + CW'(pop);
      overflow <= overflow || (issue_valid && !issue_ready);
    end
  // A write into a full FIFO means the credit accounting is broken
  assert property (@(posedge clock) disable iff (!reset_n) !(wr_en && count == CW'(DEPTH)));
endmodule
